spinner_step_gen: RTL and testbench

- Transmit side of the spinner counter chain.
- Converts signed position deltas from the host (mouse or paddle) into step-clock pulses plus an up/down level for the cascaded up/down counters that the game CPU reads.
- Sits between the host input interface and the counter's clk, u_d and count-enable pins.
- Guarantees direction setup before every counting edge, and paces pulses so no motion is lost.

---
 rtl/spinner_step_gen.sv | 199 +++++++++++++++++++
 tb/tb_spinner_step_gen.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spinner_step_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : spinner_step_gen                                              |
// | Purpose  : Turns signed host motion deltas into step_clk pulses plus an  |
// |            up/down level for a cascaded up/down counter chain. The       |
// |            direction is set up before every counting edge, and pulses    |
// |            are paced so that no motion is lost.                          |
// | Option   : SPINNER_ACCEL_EN - halves the inter-pulse gap while |acc| >   |
// |            ACCEL_THR and adds the accel_active output. The ACCEL_THR     |
// |            parameter exists only in that build.                          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module spinner_step_gen #(
  parameter int ACC_W     = 10,
  parameter int SETUP_CYC = 2,
  parameter int HIGH_CYC  = 4,
  parameter int GAP_CYC   = 4
`ifdef SPINNER_ACCEL_EN
  ,
  parameter int ACCEL_THR = 64
`endif
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       delta_valid,
  input  logic [7:0] delta,
  output logic       step_clk,
  output logic       u_d,
  output logic       n_en,
  output logic       busy,
  output logic       overflow
`ifdef SPINNER_ACCEL_EN
  ,
  output logic       accel_active
`endif
);

  // State encoding
  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_SETUP    = 2'd1;
  localparam logic [1:0] S_PULSE_HI = 2'd2;
  localparam logic [1:0] S_PULSE_LO = 2'd3;

  // Timer sizing: the counter holds (duration - 1) of the longest state
  localparam int MAX_CYC_A = (SETUP_CYC > HIGH_CYC) ? SETUP_CYC : HIGH_CYC;
  localparam int MAX_CYC   = (MAX_CYC_A > GAP_CYC) ? MAX_CYC_A : GAP_CYC;
  localparam int CNT_W     = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] SETUP_INIT = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] HIGH_INIT  = CNT_W'(HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_INIT   = CNT_W'(GAP_CYC - 1);

  // Saturation limits are symmetric, so the most negative code is never used
  localparam logic signed [ACC_W:0] ACC_MAX  = (ACC_W+1)'((1 << (ACC_W - 1)) - 1);
  localparam logic signed [ACC_W:0] ACC_MIN  = -ACC_MAX;
  localparam logic signed [ACC_W:0] ONE_EXT  = (ACC_W+1)'(1);
  localparam logic signed [ACC_W:0] MONE_EXT = -ONE_EXT;

  logic [1:0]              state;
  logic [CNT_W-1:0]        cnt;
  logic signed [ACC_W-1:0] acc;

  logic                    acc_nz;
  logic                    acc_pos;
  logic                    abort;
  logic                    fire;
  logic [CNT_W-1:0]        gap_init;
  logic signed [ACC_W:0]   acc_ext;
  logic signed [ACC_W:0]   add_term;
  logic signed [ACC_W:0]   take_term;
  logic signed [ACC_W:0]   sum;
  logic signed [ACC_W:0]   sum_sat;
  logic                    sat_hit;

  assign acc_nz  = (acc != '0);
  assign acc_pos = acc_nz && !acc[ACC_W-1];

  // A step is only issued if the pending motion still points the latched way
  assign abort = !acc_nz || (acc_pos != u_d);
  assign fire  = (state == S_SETUP) && (cnt == '0) && !abort;

  assign busy = (state != S_IDLE) || acc_nz;

`ifdef SPINNER_ACCEL_EN
  localparam logic [CNT_W-1:0] GAP_SHORT_INIT = CNT_W'(((GAP_CYC + 1) / 2) - 1);

  logic [ACC_W-1:0] acc_mag;
  logic             gap_short;

  assign acc_mag   = acc[ACC_W-1] ? (~acc + 1'b1) : acc;
  assign gap_short = (int'({1'b0, acc_mag}) > ACCEL_THR);
  assign gap_init  = gap_short ? GAP_SHORT_INIT : GAP_INIT;
`else
  assign gap_init  = GAP_INIT;
`endif

  // Next accumulator value: new motion in, issued step out, then clamp
  always_comb begin
    acc_ext   = {acc[ACC_W-1], acc};
    add_term  = delta_valid ? {{(ACC_W-7){delta[7]}}, delta} : '0;
    take_term = fire ? (u_d ? ONE_EXT : MONE_EXT) : '0;
    sum       = acc_ext + add_term - take_term;
    sat_hit   = 1'b0;
    sum_sat   = sum;
    if (sum > ACC_MAX) begin
      sum_sat = ACC_MAX;
      sat_hit = 1'b1;
    end else if (sum < ACC_MIN) begin
      sum_sat = ACC_MIN;
      sat_hit = 1'b1;
    end
  end

  // Accumulator and sticky overflow flag
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      acc      <= '0;
      overflow <= 1'b0;
    end else begin
      acc <= sum_sat[ACC_W-1:0];
      if (sat_hit) begin
        overflow <= 1'b1;
      end
    end
  end

  // Pulse sequencer: direction setup, high phase, gap, repeat while motion remains
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      step_clk <= 1'b0;
      u_d      <= 1'b1;
      n_en     <= 1'b1;
`ifdef SPINNER_ACCEL_EN
      accel_active <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (acc_nz) begin
            state <= S_SETUP;
            cnt   <= SETUP_INIT;
            u_d   <= acc_pos;
            n_en  <= 1'b0;
          end
        end
        S_SETUP: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else if (abort) begin
            // Motion vanished or reversed during setup: drop out, keep u_d
            state <= S_IDLE;
            n_en  <= 1'b1;
          end else begin
            state    <= S_PULSE_HI;
            cnt      <= HIGH_INIT;
            step_clk <= 1'b1;
          end
        end
        S_PULSE_HI: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            state    <= S_PULSE_LO;
            cnt      <= gap_init;
            step_clk <= 1'b0;
`ifdef SPINNER_ACCEL_EN
            accel_active <= gap_short;
`endif
          end
        end
        S_PULSE_LO: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
`ifdef SPINNER_ACCEL_EN
            accel_active <= 1'b0;
`endif
            if (acc_nz) begin
              state <= S_SETUP;
              cnt   <= SETUP_INIT;
              u_d   <= acc_pos;
            end else begin
              state <= S_IDLE;
              n_en  <= 1'b1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          n_en  <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spinner_step_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_spinner_step_gen                                           |
// | Purpose  : Directed self-checking bench for spinner_step_gen at default  |
// |            parameters. Samples are logged 1 ns after each rising edge;   |
// |            sample k is the state just after edge k of a sequence.        |
// |            Build with SPINNER_ACCEL_EN to exercise the shortened gap.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_spinner_step_gen;

  logic       clk;
  logic       n_reset;
  logic       delta_valid;
  logic [7:0] delta;
  logic       step_clk;
  logic       u_d;
  logic       n_en;
  logic       busy;
  logic       overflow;
`ifdef SPINNER_ACCEL_EN
  logic       accel_active;
`endif

  int n_checks;
  int n_pass;

  localparam int LOG_N = 256;
  int idx;
  bit s_step [0:LOG_N-1];
  bit s_ud   [0:LOG_N-1];
  bit s_ne   [0:LOG_N-1];
  bit s_bz   [0:LOG_N-1];
  bit s_ov   [0:LOG_N-1];
  bit s_aa   [0:LOG_N-1];
  int s_acc  [0:LOG_N-1];

  spinner_step_gen dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .delta_valid (delta_valid),
    .delta       (delta),
    .step_clk    (step_clk),
    .u_d         (u_d),
    .n_en        (n_en),
    .busy        (busy),
    .overflow    (overflow)
`ifdef SPINNER_ACCEL_EN
    ,
    .accel_active(accel_active)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for every check in the bench
  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic record(input int k);
    s_step[k] = step_clk;
    s_ud[k]   = u_d;
    s_ne[k]   = n_en;
    s_bz[k]   = busy;
    s_ov[k]   = overflow;
    s_acc[k]  = int'(dut.acc);
`ifdef SPINNER_ACCEL_EN
    s_aa[k]   = accel_active;
`else
    s_aa[k]   = 1'b0;
`endif
  endtask

  task automatic begin_log();
    idx = 0;
    record(0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (idx < LOG_N - 1) idx++;
    record(idx);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic apply(input logic v, input logic [7:0] d);
    delta_valid = v;
    delta       = d;
  endtask

  function automatic int rise_at(input int nth);
    int n;
    n = 0;
    for (int k = 1; k <= idx; k++) begin
      if (s_step[k] && !s_step[k-1]) begin
        n++;
        if (n == nth) return k;
      end
    end
    return -1;
  endfunction

  function automatic int count_rises();
    int n;
    n = 0;
    for (int k = 1; k <= idx; k++) if (s_step[k] && !s_step[k-1]) n++;
    return n;
  endfunction

  function automatic int count_high(input int lo, input int hi);
    int n;
    n = 0;
    for (int k = lo; k <= hi; k++) if (s_step[k]) n++;
    return n;
  endfunction

  // Samples where counting is enabled but u_d differs from the expected level
  function automatic int count_ud_bad(input bit want, input int lo, input int hi);
    int n;
    n = 0;
    for (int k = lo; k <= hi; k++) if (!s_ne[k] && (s_ud[k] != want)) n++;
    return n;
  endfunction

  function automatic int count_busy(input int lo, input int hi);
    int n;
    n = 0;
    for (int k = lo; k <= hi; k++) if (s_bz[k]) n++;
    return n;
  endfunction

  function automatic int count_ov_low(input int lo, input int hi);
    int n;
    n = 0;
    for (int k = lo; k <= hi; k++) if (!s_ov[k]) n++;
    return n;
  endfunction

  task automatic do_reset();
    n_reset = 1'b0;
    apply(1'b0, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    n_reset = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    idx      = 0;
    n_reset  = 1'b0;
    apply(1'b0, 8'h00);

    // Reset state
    do_reset();
    check("rst_step_clk", step_clk, 0);
    check("rst_u_d", u_d, 1);
    check("rst_n_en", n_en, 1);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);
    check("rst_acc", int'(dut.acc), 0);

    // Zero delta with valid is a no-op
    begin_log();
    apply(1'b1, 8'h00); tick();
    apply(1'b0, 8'h00); ticks(5);
    check("zero_busy_samples", count_busy(1, 6), 0);

    // +3: three pulses, 4 high / 6 low, period 10
    begin_log();
    apply(1'b1, 8'd3); tick();
    apply(1'b0, 8'h00); ticks(39);
    check("p3_acc_s1", s_acc[1], 3);
    check("p3_n_en_setup", s_ne[2], 0);
    check("p3_rises", count_rises(), 3);
    check("p3_rise1", rise_at(1), 4);
    check("p3_rise2", rise_at(2), 14);
    check("p3_rise3", rise_at(3), 24);
    check("p3_high_len", count_high(4, 13), 4);
    check("p3_ud_level", count_ud_bad(1'b1, 1, 40), 0);
    check("p3_busy_s31", s_bz[31], 1);
    check("p3_busy_s32", s_bz[32], 0);
    check("p3_n_en_s32", s_ne[32], 1);
    check("p3_acc_end", s_acc[40], 0);

    // -2: u_d falls on SETUP entry and is held 2 cycles before the first rise
    begin_log();
    apply(1'b1, 8'hFE); tick();
    apply(1'b0, 8'h00); ticks(29);
    check("m2_ud_s1", s_ud[1], 1);
    check("m2_ud_s2", s_ud[2], 0);
    check("m2_ud_s3", s_ud[3], 0);
    check("m2_step_s3", s_step[3], 0);
    check("m2_step_s4", s_step[4], 1);
    check("m2_rises", count_rises(), 2);
    check("m2_rise2", rise_at(2), 14);
    check("m2_ud_level", count_ud_bad(1'b0, 2, 30), 0);
    check("m2_busy_s22", s_bz[22], 0);

    // +5 then -5 during the first high phase: one up pulse, then one down pulse
    do_reset();
    begin_log();
    apply(1'b1, 8'd5); tick();
    apply(1'b0, 8'h00); ticks(3);
    apply(1'b1, 8'hFB); tick();
    apply(1'b0, 8'h00); ticks(25);
    check("rev_acc_s4", s_acc[4], 4);
    check("rev_acc_s5", s_acc[5], -1);
    check("rev_ud_s11", s_ud[11], 1);
    check("rev_ud_s12", s_ud[12], 0);
    check("rev_rises", count_rises(), 2);
    check("rev_rise2", rise_at(2), 14);
    check("rev_acc_end", s_acc[30], 0);
    check("rev_busy_s22", s_bz[22], 0);

    // Negative boundary: -511 reached exactly without saturating, then clamps
    do_reset();
    begin_log();
    apply(1'b1, 8'h80); ticks(5);
    apply(1'b0, 8'h00); tick();
    check("neg_acc_s3", s_acc[3], -384);
    check("neg_acc_s4", s_acc[4], -511);
    check("neg_ov_s4", s_ov[4], 0);
    check("neg_acc_s5", s_acc[5], -511);
    check("neg_ov_s5", s_ov[5], 1);

    // +127 on eight cycles: saturates at 511, overflow sticks while draining
    do_reset();
    begin_log();
    apply(1'b1, 8'd127); ticks(8);
    apply(1'b0, 8'h00); ticks(97);
    check("sat_acc_s4", s_acc[4], 507);
    check("sat_ov_s4", s_ov[4], 0);
    check("sat_acc_s5", s_acc[5], 511);
    check("sat_ov_s5", s_ov[5], 1);
    check("sat_acc_s8", s_acc[8], 511);
    check("sat_ov_sticky", count_ov_low(5, 105), 0);
    check("sat_rises", count_rises(), 11);
    check("sat_acc_s105", s_acc[105], 501);
    check("sat_step_s105", s_step[105], 1);

    // Asynchronous reset in the middle of the high phase
    n_reset = 1'b0;
    #1;
    check("arst_step_clk", step_clk, 0);
    check("arst_n_en", n_en, 1);
    check("arst_u_d", u_d, 1);
    check("arst_acc", int'(dut.acc), 0);
    check("arst_overflow", overflow, 0);
    check("arst_busy", busy, 0);
    @(posedge clk);
    #1;
    n_reset = 1'b1;
    begin_log();
    ticks(30);
    check("arst_no_rises", count_rises(), 0);
    check("arst_no_busy", count_busy(1, 30), 0);

`ifdef SPINNER_ACCEL_EN
    // +100: first gap shortened to 2 cycles while |acc| > 64
    do_reset();
    begin_log();
    apply(1'b1, 8'd100); tick();
    apply(1'b0, 8'h00); ticks(29);
    check("acc_rise1", rise_at(1), 4);
    check("acc_acc_s7", s_acc[7], 99);
    check("acc_aa_s7", s_aa[7], 0);
    check("acc_aa_s8", s_aa[8], 1);
    check("acc_aa_s9", s_aa[9], 1);
    check("acc_aa_s10", s_aa[10], 0);
    check("acc_rise2", rise_at(2), 12);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
